// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader.
// Receives a byte stream (length hi, length lo, then length x {instr hi, instr lo})
// over a valid/ready handshake, writes each assembled big-endian word to the
// instruction memory at consecutive addresses, and keeps the CPU in reset until
// the load has finished successfully.
module inst_loader #(
    parameter int INST_ADDR_WIDTH     = 16,
    parameter int INST_DATA_BIT_WIDTH = 16,
    parameter int INST_MEM_SIZE       = 26,
    parameter int NUM_BYTES_IN_INST   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           byte_valid,
    input  logic [7:0]                     byte_data,
    output logic                           byte_ready,
    output logic                           mem_wr,
    output logic [INST_ADDR_WIDTH-1:0]     mem_addr,
    output logic [INST_DATA_BIT_WIDTH-1:0] mem_data,
    output logic                           cpu_hold,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [INST_ADDR_WIDTH-1:0]     words_loaded
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN_HI  = 3'd1;
    localparam logic [2:0] ST_LEN_LO  = 3'd2;
    localparam logic [2:0] ST_DATA_HI = 3'd3;
    localparam logic [2:0] ST_DATA_LO = 3'd4;
    localparam logic [2:0] ST_WRITE   = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_ERROR   = 3'd7;

    localparam logic [15:0]                MAX_LEN   = 16'(INST_MEM_SIZE);
    localparam logic [INST_ADDR_WIDTH-1:0] ADDR_STEP = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
    localparam logic [INST_ADDR_WIDTH-1:0] WORD_ONE  = INST_ADDR_WIDTH'(1);

    // States in which the loader consumes stream bytes.
    function automatic logic is_rx_state(input logic [2:0] st);
        logic rx;
        case (st)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: rx = 1'b1;
            default:                                      rx = 1'b0;
        endcase
        return rx;
    endfunction

    // States that make up an active load (LEN_HI through WRITE).
    function automatic logic is_busy_state(input logic [2:0] st);
        logic bz;
        case (st)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_WRITE: bz = 1'b1;
            default:                                                bz = 1'b0;
        endcase
        return bz;
    endfunction

    logic [2:0]                     state_r;
    logic [2:0]                     state_next_s;
    logic [15:0]                    length_r;
    logic [15:0]                    len_full_s;
    logic [INST_ADDR_WIDTH-1:0]     words_loaded_r;
    logic [INST_ADDR_WIDTH-1:0]     words_inc_s;
    logic [INST_ADDR_WIDTH-1:0]     mem_addr_r;
    logic [INST_DATA_BIT_WIDTH-1:0] mem_data_r;
    logic                           byte_ready_r;
    logic                           mem_wr_r;
    logic                           cpu_hold_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           error_r;
    logic                           xfer_s;

    // byte_ready_r always mirrors the current state, so the handshake has no
    // combinational path from byte_valid.
    assign xfer_s      = byte_valid && byte_ready_r;
    assign len_full_s  = {length_r[15:8], byte_data};
    assign words_inc_s = words_loaded_r + WORD_ONE;

    // Next-state decode for the load sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next_s = ST_LEN_HI;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    state_next_s = ST_LEN_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (!xfer_s) begin
                    state_next_s = state_r;
                end else if (len_full_s == 16'h0000) begin
                    state_next_s = ST_DONE;
                end else if (len_full_s > MAX_LEN) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (xfer_s) begin
                    state_next_s = ST_DATA_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DATA_LO: begin
                if (xfer_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WRITE: begin
                if (words_inc_s == INST_ADDR_WIDTH'(length_r)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DATA_HI;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and status outputs, registered from the next state so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            byte_ready_r <= 1'b0;
            mem_wr_r     <= 1'b0;
            cpu_hold_r   <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            byte_ready_r <= is_rx_state(state_next_s);
            mem_wr_r     <= (state_next_s == ST_WRITE);
            cpu_hold_r   <= (state_next_s != ST_DONE);
            busy_r       <= is_busy_state(state_next_s);
            done_r       <= (state_next_s == ST_DONE);
            error_r      <= (state_next_s == ST_ERROR);
        end
    end

    // Datapath: length capture, word assembly, address and word counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            length_r       <= 16'h0000;
            mem_data_r     <= '0;
            mem_addr_r     <= '0;
            words_loaded_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        mem_addr_r     <= '0;
                        words_loaded_r <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer_s) begin
                        length_r[15:8] <= byte_data;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer_s) begin
                        length_r[7:0] <= byte_data;
                    end
                end
                ST_DATA_HI: begin
                    if (xfer_s) begin
                        mem_data_r[INST_DATA_BIT_WIDTH-1 -: 8] <= byte_data;
                    end
                end
                ST_DATA_LO: begin
                    if (xfer_s) begin
                        mem_data_r[7:0] <= byte_data;
                    end
                end
                ST_WRITE: begin
                    // Address/count advance after the write cycle, keeping
                    // mem_addr stable while mem_wr is high.
                    mem_addr_r     <= mem_addr_r + ADDR_STEP;
                    words_loaded_r <= words_inc_s;
                end
                default: begin
                    length_r <= length_r;
                end
            endcase
        end
    end

    assign byte_ready   = byte_ready_r;
    assign mem_wr       = mem_wr_r;
    assign mem_addr     = mem_addr_r;
    assign mem_data     = mem_data_r;
    assign cpu_hold     = cpu_hold_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: scoreboard of expected memory writes,
// status checks after each stream.
module tb_inst_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_wr_cyc = 0;
    int wr_count = 0;
    logic spacing_en = 1'b0;
    logic [31:0] exp_q[$];

    inst_loader dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every write strobe is matched against the queued expectation.
    always @(negedge clk) begin
        if (rst && mem_wr) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", {mem_addr, mem_data}, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {16'h0, mem_addr}, {16'h0, e[31:16]});
                chk("wr_data", {16'h0, mem_data}, {16'h0, e[15:0]});
            end
            if (spacing_en && words_loaded != 16'h0)
                chk("wr_spacing", cyc - last_wr_cyc, 32'd3);
            last_wr_cyc = cyc;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and return on the negedge after it was accepted.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'h0, byte_ready}, 32'd0);
        chk({tag, "_wr"},    {31'h0, mem_wr},     32'd0);
        chk({tag, "_addr"},  {16'h0, mem_addr},   32'd0);
        chk({tag, "_data"},  {16'h0, mem_data},   32'd0);
        chk({tag, "_hold"},  {31'h0, cpu_hold},   32'd1);
        chk({tag, "_busy"},  {31'h0, busy},       32'd0);
        chk({tag, "_done"},  {31'h0, done},       32'd0);
        chk({tag, "_err"},   {31'h0, error},      32'd0);
        chk({tag, "_words"}, {16'h0, words_loaded}, 32'd0);
    endtask

    initial begin
        int wc;
        logic [15:0] d;
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b1;
        @(negedge clk);

        // Two-word load, byte_valid held high.
        spacing_en = 1'b1;
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0002, 16'hABCD});
        pulse_start();
        chk("t2_busy", {31'h0, busy}, 32'd1);
        send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        byte_valid = 1'b0;
        chk("t2_done_not_yet", {31'h0, done}, 32'd0);
        @(negedge clk);
        chk("t2_done",  {31'h0, done},     32'd1);
        chk("t2_hold",  {31'h0, cpu_hold}, 32'd0);
        chk("t2_words", {16'h0, words_loaded}, 32'd2);
        chk("t2_nwr",   wr_count, 32'd2);

        // Reload from DONE.
        exp_q.push_back({16'h0000, 16'hFF00});
        pulse_start();
        chk("t3_hold",  {31'h0, cpu_hold}, 32'd1);
        chk("t3_done",  {31'h0, done},     32'd0);
        chk("t3_words", {16'h0, words_loaded}, 32'd0);
        chk("t3_addr",  {16'h0, mem_addr}, 32'd0);
        send(8'h00); send(8'h01); send(8'hFF); send(8'h00);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("t3_done2", {31'h0, done}, 32'd1);
        chk("t3_nwr",   wr_count, 32'd3);

        // Maximum length: 26 words, last at 0x0032.
        pulse_start();
        send(8'h00); send(8'h1A);
        for (int k = 0; k < 26; k++) begin
            d = 16'($urandom);
            exp_q.push_back({16'(2 * k), d});
            send(d[15:8]); send(d[7:0]);
        end
        byte_valid = 1'b0;
        @(negedge clk);
        chk("t4_done",  {31'h0, done}, 32'd1);
        chk("t4_words", {16'h0, words_loaded}, 32'd26);
        chk("t4_nwr",   wr_count, 32'd29);
        spacing_en = 1'b0;

        // Oversize length 27 -> ERROR, no write, further bytes not consumed.
        pulse_start();
        send(8'h00); send(8'h1B);
        chk("t5_err",   {31'h0, error},    32'd1);
        chk("t5_hold",  {31'h0, cpu_hold}, 32'd1);
        chk("t5_busy",  {31'h0, busy},     32'd0);
        byte_data = 8'h77;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("t5_ready", {31'h0, byte_ready}, 32'd0);
        chk("t5_sticky", {31'h0, error},   32'd1);
        byte_valid = 1'b0;
        chk("t5_nwr",   wr_count, 32'd29);

        // Zero length from ERROR.
        pulse_start();
        chk("t6_err_clr", {31'h0, error}, 32'd0);
        send(8'h00); send(8'h00);
        byte_valid = 1'b0;
        chk("t6_done",  {31'h0, done}, 32'd1);
        chk("t6_words", {16'h0, words_loaded}, 32'd0);
        chk("t6_nwr",   wr_count, 32'd29);

        // Stalled stream 00 01 5A 5A with 4-cycle gaps.
        exp_q.push_back({16'h0000, 16'h5A5A});
        pulse_start();
        send(8'h00);
        for (int j = 0; j < 3; j++) begin
            byte_valid = 1'b0;
            for (int i = 0; i < 4; i++) @(negedge clk);
            chk("t7_stall_ready", {31'h0, byte_ready}, 32'd1);
            chk("t7_stall_busy",  {31'h0, busy},       32'd1);
            if (j == 0) send(8'h01);
            else        send(8'h5A);
        end
        byte_valid = 1'b0;
        start = 1'b1;              // coincides with the WRITE cycle; must be ignored
        @(negedge clk);
        start = 1'b0;
        chk("t7_done",  {31'h0, done}, 32'd1);
        chk("t7_busy",  {31'h0, busy}, 32'd0);
        chk("t7_nwr",   wr_count, 32'd30);

        // Reset during an active load.
        exp_q.push_back({16'h0000, 16'h1122});
        pulse_start();
        send(8'h00); send(8'h05); send(8'h11); send(8'h22); send(8'h33);
        wc = wr_count;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        byte_valid = 1'b0;
        check_reset_vals("postrst");
        chk("t8_nwr",   wr_count, wc);
        chk("t8_total", wc, 32'd31);
        chk("q_empty",  exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that writes the CPU's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written to instruction memory at consecutive instruction addresses. The pipeline is held in reset until the load completes. It sits beside the CPU top level, drives the instruction memory write port, and gates the core's reset.

## Interface
- INST_ADDR_WIDTH, 16, instruction byte-address width
- INST_DATA_BIT_WIDTH, 16, instruction word width (two bytes)
- INST_MEM_SIZE, 26, instruction memory capacity in words
- NUM_BYTES_IN_INST, 2, address increment per word
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE, DONE or ERROR
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- mem_wr  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  INST_ADDR_WIDTH  write byte address
- mem_data  out  INST_DATA_BIT_WIDTH  write word
- cpu_hold  out  1  holds the CPU in reset while high
- busy  out  1  load in progress
- done  out  1  load completed successfully
- error  out  1  length rejected
- words_loaded  out  INST_ADDR_WIDTH  words written in the current/last load

## Operation
- A byte is transferred on a rising clk edge when byte_valid && byte_ready are both high. Nothing is transferred otherwise.
- Stream format: length high byte, length low byte, then length × (instruction high byte, instruction low byte).
- States and transitions:
  - IDLE: entered on reset. start -> LEN_HI; clears words_loaded, mem_addr, done and error.
  - LEN_HI: on a transfer, capture the length high byte -> LEN_LO.
  - LEN_LO: on a transfer, capture the length low byte.
    - Length 0 -> DONE.
    - Length > INST_MEM_SIZE -> ERROR.
    - Otherwise -> DATA_HI.
  - DATA_HI: on a transfer, capture byte into mem_data[15:8] -> DATA_LO.
  - DATA_LO: on a transfer, capture byte into mem_data[7:0] -> WRITE.
  - WRITE: mem_wr=1 for exactly one cycle.
    - Next edge: mem_addr += NUM_BYTES_IN_INST and words_loaded += 1.
    - words_loaded+1 == length -> DONE, else -> DATA_HI.
  - DONE: done=1, cpu_hold=0. start -> LEN_HI, which clears done, words_loaded and mem_addr and sets cpu_hold=1.
  - ERROR: error=1 (sticky), cpu_hold=1. start -> LEN_HI and clears error.
- byte_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO. It is 0 in IDLE, WRITE, DONE and ERROR, so bytes presented there are not consumed.
- busy=1 in LEN_HI through WRITE. start is ignored while busy.
- cpu_hold=1 in every state except DONE.
- Address arithmetic: first word at 0, word k at k×NUM_BYTES_IN_INST. mem_addr never wraps, because length ≤ INST_MEM_SIZE is enforced before any write.

## Timing
- Reset values (asynchronous on rst=0):
  - state IDLE
  - byte_ready 0, mem_wr 0, mem_addr 0, mem_data 0
  - cpu_hold 1, busy 0, done 0, error 0, words_loaded 0
- All outputs are registered or decoded from registered state only; there is no combinational path from byte_valid to byte_ready.
- Minimum 3 cycles per word (DATA_HI, DATA_LO, WRITE) with byte_valid held high.
- mem_addr and mem_data are stable throughout the mem_wr cycle.
- After the final WRITE cycle, done rises and cpu_hold falls on the next edge.
- ERROR is entered on the edge that accepts the length low byte, with no mem_wr ever issued.
- Stalls: byte_valid low in any receiving state holds the state and all captured values indefinitely.
- Reset mid-load: immediate return to reset values. The partial load is abandoned; words already written stay in memory. cpu_hold stays 1.
- start asserted in the same cycle as the last WRITE is ignored (busy).

## Test plan
- Reset with rst=0 during an active load -> all outputs at reset values; cpu_hold=1; no further mem_wr.
- start, stream 00 02 12 34 AB CD with byte_valid held high:
  - mem_wr pulses twice: addr 0x0000/data 0x1234, then addr 0x0002/data 0xABCD.
  - Loads 3 cycles apart.
  - Ends with done=1, cpu_hold=0, words_loaded=2.
- Length 00 1A (26) -> 26 writes, last at addr 0x0032, then done. Length 00 1B -> error=1 and cpu_hold=1, with no mem_wr.
- Length 00 00 -> DONE immediately after the second byte; words_loaded=0; no mem_wr.
- Stream 00 01 5A 5A with byte_valid deasserted for 4 cycles between bytes -> state held with byte_ready high; a single write of 0x5A5A at addr 0.
- From DONE, start and a second load of 00 01 FF 00 -> cpu_hold returns to 1, done clears, the word is written at addr 0x0000, then done again.
